// File: rtl/mxint_matrix_split_pkg.sv
// Shared types and elaboration helpers for the MXINT row-split stage.
package mxint_matrix_split_pkg;

  typedef enum logic {
    SEG_0 = 1'b0,
    SEG_1 = 1'b1
  } seg_state_e;

  function automatic int block_count(input int width, input int par);
    return width / par;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mxint_matrix_split_reg.sv
// One-entry valid/ready register holding one MXINT beat (mantissa block plus shared exponent).
module mx_pipe_reg #(
  parameter int DATA_W     = 8,
  parameter int EXP_W      = 8,
  parameter int BLOCK_SIZE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic signed [DATA_W-1:0] load_mdata [BLOCK_SIZE],
  input  logic        [EXP_W-1:0]  load_edata,
  output logic signed [DATA_W-1:0] mdata [BLOCK_SIZE],
  output logic        [EXP_W-1:0]  edata,
  output logic                     valid,
  input  logic                     ready,
  output logic                     space
);

  // A load in the same cycle as a drain keeps valid high with the new beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      edata <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) mdata[i] <= '0;
    end else if (load) begin
      valid <= 1'b1;
      edata <= load_edata;
      for (int i = 0; i < BLOCK_SIZE; i++) mdata[i] <= load_mdata[i];
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

  assign space = !valid || ready;

endmodule

// File: rtl/mxint_matrix_split.sv
// Splits each MXINT row into its first W0 columns (output 0) and remaining W1 columns (output 1).
module mxint_matrix_split
  import mxint_matrix_split_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 8,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 2,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int DATA_OUT_0_TENSOR_SIZE_DIM_0 = 4,
  parameter int DATA_OUT_1_TENSOR_SIZE_DIM_0 = 4,
  localparam int BLOCK_SIZE = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic signed [DATA_IN_0_PRECISION_0-1:0] mdata_in_0 [BLOCK_SIZE],
  input  logic        [DATA_IN_0_PRECISION_1-1:0] edata_in_0,
  input  logic                                    data_in_0_valid,
  output logic                                    data_in_0_ready,
  output logic signed [DATA_IN_0_PRECISION_0-1:0] mdata_out_0 [BLOCK_SIZE],
  output logic        [DATA_IN_0_PRECISION_1-1:0] edata_out_0,
  output logic                                    data_out_0_valid,
  input  logic                                    data_out_0_ready,
  output logic signed [DATA_IN_0_PRECISION_0-1:0] mdata_out_1 [BLOCK_SIZE],
  output logic        [DATA_IN_0_PRECISION_1-1:0] edata_out_1,
  output logic                                    data_out_1_valid,
  input  logic                                    data_out_1_ready
);

  localparam int B0   = block_count(DATA_OUT_0_TENSOR_SIZE_DIM_0, DATA_IN_0_PARALLELISM_DIM_0);
  localparam int B1   = block_count(DATA_OUT_1_TENSOR_SIZE_DIM_0, DATA_IN_0_PARALLELISM_DIM_0);
  localparam int ROWS = block_count(DATA_IN_0_TENSOR_SIZE_DIM_1, DATA_IN_0_PARALLELISM_DIM_1);
  localparam int CW   = $clog2(max_int(B0, B1)) + 1;
  localparam int RW   = $clog2(ROWS) + 1;
  localparam logic [CW-1:0] B0_LAST  = CW'(B0 - 1);
  localparam logic [CW-1:0] B1_LAST  = CW'(B1 - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  if (DATA_OUT_0_TENSOR_SIZE_DIM_0 + DATA_OUT_1_TENSOR_SIZE_DIM_0 != DATA_IN_0_TENSOR_SIZE_DIM_0) begin : g_bad_sum
    $error("output widths must add up to the input row width");
  end
  if ((DATA_OUT_0_TENSOR_SIZE_DIM_0 % DATA_IN_0_PARALLELISM_DIM_0 != 0) ||
      (DATA_OUT_1_TENSOR_SIZE_DIM_0 % DATA_IN_0_PARALLELISM_DIM_0 != 0)) begin : g_bad_align
    $error("output widths must be whole numbers of blocks");
  end
  if (B0 < 1 || B1 < 1) begin : g_bad_blocks
    $error("each output segment needs at least one block");
  end

  seg_state_e      state;
  logic [CW-1:0]   col_cntr;
  logic [RW-1:0]   row_cntr;
  logic            space_0;
  logic            space_1;
  logic            xfer;

  assign data_in_0_ready = (state == SEG_0) ? space_0 : space_1;
  assign xfer            = data_in_0_valid && data_in_0_ready;

  // Segment FSM: B0 blocks to output 0, then B1 blocks to output 1, per row.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEG_0;
      col_cntr <= '0;
      row_cntr <= '0;
    end else if (xfer) begin
      if (state == SEG_0) begin
        if (col_cntr == B0_LAST) begin
          col_cntr <= '0;
          state    <= SEG_1;
        end else begin
          col_cntr <= col_cntr + CW'(1);
        end
      end else begin
        if (col_cntr == B1_LAST) begin
          col_cntr <= '0;
          state    <= SEG_0;
          row_cntr <= (row_cntr == ROW_LAST) ? '0 : row_cntr + RW'(1);
        end else begin
          col_cntr <= col_cntr + CW'(1);
        end
      end
    end
  end

  mx_pipe_reg #(
    .DATA_W    (DATA_IN_0_PRECISION_0),
    .EXP_W     (DATA_IN_0_PRECISION_1),
    .BLOCK_SIZE(BLOCK_SIZE)
  ) u_reg_0 (
    .clk       (clk),
    .rst       (rst),
    .load      (xfer && (state == SEG_0)),
    .load_mdata(mdata_in_0),
    .load_edata(edata_in_0),
    .mdata     (mdata_out_0),
    .edata     (edata_out_0),
    .valid     (data_out_0_valid),
    .ready     (data_out_0_ready),
    .space     (space_0)
  );

  mx_pipe_reg #(
    .DATA_W    (DATA_IN_0_PRECISION_0),
    .EXP_W     (DATA_IN_0_PRECISION_1),
    .BLOCK_SIZE(BLOCK_SIZE)
  ) u_reg_1 (
    .clk       (clk),
    .rst       (rst),
    .load      (xfer && (state == SEG_1)),
    .load_mdata(mdata_in_0),
    .load_edata(edata_in_0),
    .mdata     (mdata_out_1),
    .edata     (edata_out_1),
    .valid     (data_out_1_valid),
    .ready     (data_out_1_ready),
    .space     (space_1)
  );

endmodule

// File: doc/mxint_matrix_split.md
Name: mxint_matrix_split

Overview:
- Inverse of the MX concatenation stage: implements torch.split(t, [W0, W1], dim=-1) on an MXINT block stream.
- One input stream carries rows of width W0+W1, streamed left to right in blocks of BLOCK_SIZE mantissas plus one shared exponent.
- The first W0 columns of each row go to output 0; the remaining W1 columns go to output 1.
- Sits directly upstream of the concatenation stage, for example in residual/branch paths that later re-join.

Parameters:
- DATA_IN_0_PRECISION_0, 8: mantissa width, shared by all ports.
- DATA_IN_0_PRECISION_1, 8: exponent width, shared by all ports.
- DATA_IN_0_TENSOR_SIZE_DIM_0, 8: input row width; must equal W0+W1.
- DATA_IN_0_TENSOR_SIZE_DIM_1, 4: number of input rows.
- DATA_IN_0_PARALLELISM_DIM_0, 2: block columns.
- DATA_IN_0_PARALLELISM_DIM_1, 1: block rows.
- DATA_OUT_0_TENSOR_SIZE_DIM_0, 4: W0, columns routed to output 0.
- DATA_OUT_1_TENSOR_SIZE_DIM_0, 4: W1, columns routed to output 1.
- BLOCK_SIZE, PAR_DIM_0*PAR_DIM_1: mantissas per beat (localparam alias).
- Derived localparams:
  - B0 = W0/PAR_DIM_0, B1 = W1/PAR_DIM_0 (blocks per row segment).
  - ROWS = TENSOR_SIZE_DIM_1/PAR_DIM_1 (block rows per matrix).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- mdata_in_0  in  [MW-1:0] x BLOCK_SIZE  input mantissas.
- edata_in_0  in  EW  input shared exponent.
- data_in_0_valid  in  1  input valid.
- data_in_0_ready  out  1  input ready.
- mdata_out_0 / edata_out_0 / data_out_0_valid / data_out_0_ready  out/out/out/in  output 0 stream.
- mdata_out_1 / edata_out_1 / data_out_1_valid / data_out_1_ready  out/out/out/in  output 1 stream.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - state=SEG_0; col_cntr=0; row_cntr=0.
  - Both output registers empty: data_out_*_valid=0, mdata/edata outputs=0.
  - data_in_0_ready reflects empty registers on the first cycle after reset (=1).
- Reset mid-operation discards partially routed rows and clears both output registers; the next input beat is treated as column 0 of row 0.
- Elaboration asserts:
  - W0+W1 == DATA_IN_0_TENSOR_SIZE_DIM_0.
  - W0 and W1 are multiples of PAR_DIM_0.
  - B0>=1 and B1>=1.
- FSM states and counters:
  - SEG_0: route to output 0. SEG_1: route to output 1.
  - col_cntr counts blocks within the current segment; width $clog2(max(B0,B1))+1.
- Handshake:
  - data_in_0_ready = selected output register empty OR its ready high (one-entry pipeline register per output, no combinational valid path).
  - Transfer = data_in_0_valid && data_in_0_ready.
  - On transfer, the beat (all mantissas plus exponent, unmodified) is loaded into the selected output register and its valid is set.
- Transitions on transfer:
  - SEG_0: if col_cntr==B0-1, then col_cntr<=0 and state<=SEG_1; else col_cntr++.
  - SEG_1: if col_cntr==B1-1, then col_cntr<=0, state<=SEG_0, and row_cntr wraps at ROWS-1 (else increments); else col_cntr++.
- Output register: valid clears when ready is high and no new load targets it in the same cycle.
- Simultaneous drain and load on the same port keeps valid=1 with the new data.
- Latency: 1 cycle input-to-output, full throughput when the selected consumer is ready.
- Ordering:
  - The non-selected output never blocks the input.
  - A stalled output blocks input only while the FSM selects it.
  - Output 1 may still hold the previous row's last beat while output 0 accepts a new row.
- Deadlock note: consumers that require both outputs simultaneously (e.g. a downstream concatenation stage) must have FIFO depth >= B0 on the branch 0 path; this is a system requirement, documented here, not checked.

Decomposition:
- Shared mxint package: seg_state_e enum (SEG_0, SEG_1) and a block-count helper function.
- Natural sub-module: mx_pipe_reg (one-entry valid/ready register, unpacked mantissa array plus exponent), instantiated once per output.
- FSM and counters stay in the top level.

Test Plan:
- W0=W1=4, PAR=2x1, 4 rows, input blocks 1..16 with exponents = block index, both readies=1 -> out_0 receives 1,2,5,6,9,10,13,14; out_1 receives 3,4,7,8,11,12,15,16; exponents follow their data; 1-cycle latency; one beat per cycle.
- Asymmetric split W0=2, W1=6, PAR=2 -> per row, out_0 gets 1 block and out_1 gets 3; col_cntr/state wrap verified over 3 rows.
- Hold data_out_1_ready=0 while streaming -> input stalls only on the SEG_1 beat with output 1 full; SEG_0 beats still flow; no beat lost or duplicated after release.
- Random valid/ready toggling (seed-fixed, 1000 beats) -> both outputs match the reference split model; out_*_valid never drops without a handshake.
- Assert rst mid-row (after 3 beats of row 1) -> next cycle both valids=0, ready=1; the following beat appears on out_0 as column 0.
- Ready-high backpressure on out_0 with simultaneous drain and load -> valid stays 1 and new data replaces old in the same cycle.
